// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequences a preset/step/terminal count run with hold, abort, done pulse and period tally
module count_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             hold_i,
    input  logic             mode_up_i,
    input  logic             auto_reload_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] term_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] periods_o
);
    typedef enum logic {IDLE, RUN} state_e;
    state_e state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, periods_q, periods_d, load_q, load_d, term_q, term_d;
    logic done_q, done_d, mode_q, mode_d, ar_q, ar_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            periods_q <= '0;
            load_q    <= '0;
            term_q    <= '0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
            ar_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            periods_q <= periods_d;
            load_q    <= load_d;
            term_q    <= term_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            ar_q      <= ar_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        periods_d = periods_q;
        load_d    = load_q;
        term_d    = term_q;
        done_d    = 1'b0;
        mode_d    = mode_q;
        ar_d      = ar_q;
        if (state_q == IDLE) begin
            if (start_i && !abort_i) begin
                mode_d    = mode_up_i;
                ar_d      = auto_reload_i;
                load_d    = load_val_i;
                term_d    = term_val_i;
                count_d   = load_val_i;
                periods_d = '0;
                state_d   = RUN;
            end
        end else if (abort_i) begin
            state_d = IDLE;
        end else if (!hold_i) begin
            if (count_q == term_q) begin
                // terminal event: tally saturates, then reload or stop on term
                done_d    = 1'b1;
                periods_d = (&periods_q) ? periods_q : periods_q + WIDTH'(1);
                count_d   = ar_q ? load_q : count_q;
                state_d   = ar_q ? RUN : IDLE;
            end else begin
                count_d = mode_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end
    assign count_o   = count_q;
    assign busy_o    = (state_q == RUN);
    assign done_o    = done_q;
    assign periods_o = periods_q;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: scoreboard bench for count_seq_ctrl; expected output tuples are queued per scenario and popped each cycle
module tb_count_seq_ctrl;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic       start_i = 0, abort_i = 0, hold_i = 0, mode_up_i = 0, auto_reload_i = 0;
    logic [3:0] load_val_i = 0, term_val_i = 0;
    logic [3:0] count_o, periods_o;
    logic       busy_o, done_o;
    int total = 0, bad = 0;

    typedef struct {logic [3:0] c; logic b; logic d; logic [3:0] p;} exp_t;
    exp_t sb[$];

    count_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .hold_i(hold_i),
        .mode_up_i(mode_up_i), .auto_reload_i(auto_reload_i), .load_val_i(load_val_i),
        .term_val_i(term_val_i), .count_o(count_o), .busy_o(busy_o), .done_o(done_o),
        .periods_o(periods_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int b, input int d, input int p);
        exp_t e;
        e.c = 4'(c); e.b = 1'(b); e.d = 1'(d); e.p = 4'(p);
        sb.push_back(e);
    endtask

    task automatic run_cfg(input logic up, input logic ar, input logic [3:0] ld, input logic [3:0] tm);
        mode_up_i = up; auto_reload_i = ar; load_val_i = ld; term_val_i = tm; start_i = 1;
    endtask

    task automatic test_reset();
        exp_t e;
        push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) #1;
            else tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL reset[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 1) rst_n = 1;
        end
    endtask

    task automatic test_oneshot_up();
        exp_t e;
        push(3, 1, 0, 0); push(4, 1, 0, 0); push(5, 1, 0, 0); push(6, 1, 0, 0);
        push(6, 0, 1, 1); push(6, 0, 0, 1);
        run_cfg(1, 0, 3, 6);
        for (int i = 0; i < 6; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL oneshot_up[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 0) begin
                start_i = 0; load_val_i = 9; term_val_i = 0; mode_up_i = 0; auto_reload_i = 1;
            end
        end
    endtask

    task automatic test_down_reload();
        exp_t e;
        logic [3:0] seq [4];
        seq[0] = 1; seq[1] = 0; seq[2] = 15; seq[3] = 14;
        for (int k = 0; k <= 68; k++)
            push(seq[k % 4], 1, (k > 0 && k % 4 == 0) ? 1 : 0, (k / 4 > 15) ? 15 : k / 4);
        push(1, 0, 0, 15);
        run_cfg(0, 1, 1, 14);
        for (int i = 0; i < 70; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL down_reload[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 0) start_i = 0;
            if (i == 68) abort_i = 1;
        end
        abort_i = 0;
    endtask

    task automatic test_hold();
        exp_t e;
        push(0, 1, 0, 0); push(1, 1, 0, 0); push(2, 1, 0, 0); push(2, 1, 0, 0);
        push(2, 1, 0, 0); push(3, 1, 0, 0); push(3, 0, 1, 1); push(3, 0, 0, 1);
        run_cfg(1, 0, 0, 3);
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL hold[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 0) start_i = 0;
            if (i == 2) hold_i = 1;
            if (i == 4) hold_i = 0;
        end
    endtask

    task automatic test_abort();
        exp_t e;
        push(4, 1, 0, 0); push(5, 1, 0, 0); push(5, 0, 0, 0); push(5, 0, 0, 0);
        push(2, 1, 0, 0); push(3, 1, 0, 0); push(4, 1, 0, 0); push(4, 0, 1, 1); push(4, 0, 0, 1);
        run_cfg(1, 0, 4, 10);
        for (int i = 0; i < 9; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL abort[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 0) start_i = 0;
            if (i == 1) abort_i = 1;
            if (i == 2) start_i = 1;
            if (i == 3) begin
                abort_i = 0;
                run_cfg(1, 0, 2, 4);
            end
            if (i == 4) begin
                load_val_i = 8; term_val_i = 12; mode_up_i = 0; auto_reload_i = 1;
            end
            if (i == 6) start_i = 0;
        end
    endtask

    task automatic test_d0();
        exp_t e;
        push(9, 1, 0, 0); push(9, 0, 1, 1); push(9, 0, 0, 1); push(9, 1, 0, 0);
        push(9, 1, 1, 1); push(9, 1, 1, 2); push(9, 1, 1, 3); push(9, 0, 0, 3);
        run_cfg(1, 0, 9, 9);
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL d0[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 0 || i == 3) start_i = 0;
            if (i == 2) run_cfg(1, 1, 9, 9);
            if (i == 6) abort_i = 1;
        end
        abort_i = 0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        push(7, 1, 0, 0); push(8, 1, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
        run_cfg(1, 1, 7, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                #2 rst_n = 0;
                #1;
            end else tick();
            e = sb.pop_front();
            total++;
            if ({count_o, busy_o, done_o, periods_o} !== {e.c, e.b, e.d, e.p}) begin
                bad++;
                $display("FAIL async_reset[%0d] got c=%0d b=%0b d=%0b p=%0d want c=%0d b=%0b d=%0b p=%0d",
                         i, count_o, busy_o, done_o, periods_o, e.c, e.b, e.d, e.p);
            end
            if (i == 0) start_i = 0;
            if (i == 3) rst_n = 1;
        end
    endtask

    initial begin
        #2 rst_n = 0;
        test_reset();
        test_oneshot_up();
        test_down_reload();
        test_hold();
        test_abort();
        test_d0();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Sequencing controller for the 4-bit ripple up/down counter datapath.
- Turns a one-cycle start command into a controlled count run: preset to a load value, step up or down each clock, detect a terminal value, then stop or auto-reload.
- Adds hold, abort, a done pulse and a completed-period tally, so software-facing logic never drives the counter clock directly.
- Fully synchronous to one clock; sits between the command/register logic and the count datapath.

Parameters:
WIDTH, 4, bit width of count, load, terminal and period values.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset asserted).
start  input  1  begin a run; sampled only in IDLE.
abort  input  1  terminate a run immediately; highest priority.
hold  input  1  freeze counting while 1 (RUN only).
mode_up  input  1  1 = count up, 0 = count down; captured at start.
auto_reload  input  1  1 = reload and continue at terminal, 0 = one-shot; captured at start.
load_val  input  WIDTH  preset value; captured at start.
term_val  input  WIDTH  terminal value; captured at start.
count  output  WIDTH  current count value.
busy  output  1  1 while in RUN.
done  output  1  one-cycle pulse on each terminal-count event.
periods  output  WIDTH  completed terminal events since last start; saturates at all-ones.

Behaviour:
- States: IDLE, RUN. Outputs are registered.
- Reset (rst=0, async): state=IDLE, count=0, busy=0, done=0, periods=0, shadow regs=0. Same values regardless of state when reset asserts. Leaving reset takes effect on the first clock edge with rst=1.
- done defaults to 0 every cycle unless set by a terminal event below.
- IDLE:
  - start=1 and abort=0 at edge n: capture mode_up, auto_reload, load_val, term_val into shadow regs.
  - After edge n: count=load_val, busy=1, periods=0, state=RUN.
  - start=1 with abort=1: abort wins; stay IDLE with no change.
  - Otherwise count holds its value.
- RUN, priority order per edge:
  1. abort=1: state=IDLE, busy=0, done=0, count and periods hold.
  2. hold=1: count frozen; no terminal comparison; done=0.
  3. count==term_s:
     - done=1 for this cycle.
     - periods+1, saturating at 2^WIDTH-1.
     - auto_reload_s=1: count=load_s, stay RUN.
     - auto_reload_s=0: state=IDLE, busy=0, count holds term_s.
  4. Else: count = count+1 (up) or count-1 (down), modulo 2^WIDTH. Wrap is 15->0 up and 0->15 down for WIDTH=4.
- start in RUN is ignored. Input changes in RUN are ignored; only the shadow values are used.
- Latency:
  - done asserts after edge n+d+1, where d = steps from load_s to term_s in the counting direction, modulo 2^WIDTH.
  - Each held cycle adds one edge.
  - load_val==term_val gives d=0: done after edge n+1.
  - Auto-reload period = d+1 cycles.
- Terminal can be reached via wrap. Example: up, load 14, term 1 gives 14, 15, 0, 1, then done.
- Reset mid-run: immediate IDLE with all outputs at reset values; no done.

Test Plan:
- Reset then one-shot up: load 3, term 6, start at edge n -> count 3,4,5,6 after n..n+3; done=1, busy=0, periods=1 after n+4; count stays 6.
- Down with wrap, auto-reload: load 1, term 14, mode_up=0 -> count 1,0,15,14; done pulse every 4 cycles; periods 1,2,3...; saturates at 15 after 15 periods; count keeps reloading to 1.
- Hold: up, load 0, term 3; hold=1 for 2 cycles while count=2 -> count stays 2 for those cycles; done delayed by exactly 2 cycles to edge n+6.
- Abort and collisions: abort with count=5 mid-run -> IDLE, busy=0, count 5, no done. start+abort together in IDLE -> no run starts. start during RUN -> ignored, shadow values unchanged.
- Edge case d=0: load=term=9 -> done after edge n+1. One-shot goes to IDLE; auto-reload gives done every cycle with count 9.
- Async reset mid-run: drive rst=0 between clock edges -> count=0, busy=0, done=0, periods=0 immediately, without waiting for a clock edge.
